// File: rtl/avalon_rr_arbiter2.sv
// -----------------------------------------------------------------------------
// avalon_rr_arbiter2
//
// Two-master round-robin arbiter sharing one Avalon-MM slave port.
// Master 0 is the I2C-to-Avalon bridge, master 1 a second master (debug/DMA).
// The granted master's command is muxed onto the slave. Outstanding pipelined
// reads are tracked in a small ID FIFO so every readdatavalid beat is steered
// back to the master that issued the read.
//
// Ports
//   clk               system clock
//   rst_n             asynchronous active-low reset
//   m_address         master addresses, master i at [i*ADDR_W +: ADDR_W]
//   m_read/m_write    per-master read/write requests
//   m_byteenable      per-master byte enables
//   m_writedata       per-master write data
//   m_waitrequest     per-master stall
//   m_readdata        read data, broadcast to both masters
//   m_readdatavalid   per-master read data valid
//   s_*               slave-side Avalon-MM command and response signals
//   err_rdv           sticky: readdatavalid seen with no read outstanding
//
// State table
//   state | meaning
//   IDLE  | no grant; slave command outputs forced to 0, winner picked
//   BUSY  | granted master's command forwarded until accepted or dropped
// -----------------------------------------------------------------------------
module avalon_rr_arbiter2 #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_PEND = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic [2*ADDR_W-1:0]   m_address,
    input  logic [1:0]            m_read,
    input  logic [1:0]            m_write,
    input  logic [2*DATA_W/8-1:0] m_byteenable,
    input  logic [2*DATA_W-1:0]   m_writedata,
    output logic [1:0]            m_waitrequest,
    output logic [DATA_W-1:0]     m_readdata,
    output logic [1:0]            m_readdatavalid,

    output logic [ADDR_W-1:0]     s_address,
    output logic                  s_read,
    output logic                  s_write,
    output logic [DATA_W/8-1:0]   s_byteenable,
    output logic [DATA_W-1:0]     s_writedata,
    input  logic                  s_waitrequest,
    input  logic [DATA_W-1:0]     s_readdata,
    input  logic                  s_readdatavalid,

    output logic                  err_rdv
);

    localparam int BE_W  = DATA_W / 8;
    localparam int PTR_W = (MAX_PEND > 1) ? $clog2(MAX_PEND) : 1;
    localparam int CNT_W = $clog2(MAX_PEND + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(MAX_PEND);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic r_gnt;
    logic w_gnt_nxt;
    logic r_last;        // last master served; resets to 1 so master 0 wins first
    logic w_last_nxt;

    logic [MAX_PEND-1:0] r_fifo;
    logic [PTR_W-1:0]    r_wr_ptr;
    logic [PTR_W-1:0]    r_rd_ptr;
    logic [CNT_W-1:0]    r_count;
    logic                r_err_rdv;

    logic [1:0]          w_req;
    logic                w_busy;
    logic                w_sel_read;
    logic                w_sel_write;
    logic [ADDR_W-1:0]   w_sel_addr;
    logic [BE_W-1:0]     w_sel_be;
    logic [DATA_W-1:0]   w_sel_wdata;
    logic                w_fifo_full;
    logic                w_fifo_empty;
    logic                w_read_blocked;
    logic                w_s_read;
    logic                w_s_write;
    logic                w_accept;
    logic                w_push;
    logic                w_pop;
    logic                w_head_id;

    // -------------------------------------------------------------------------
    // Request decode and command mux
    // -------------------------------------------------------------------------
    assign w_req  = m_read | m_write;
    assign w_busy = (r_state == ST_BUSY);

    assign w_sel_read  = r_gnt ? m_read[1]  : m_read[0];
    assign w_sel_write = r_gnt ? m_write[1] : m_write[0];
    assign w_sel_addr  = r_gnt ? m_address[2*ADDR_W-1:ADDR_W] : m_address[ADDR_W-1:0];
    assign w_sel_be    = r_gnt ? m_byteenable[2*BE_W-1:BE_W]  : m_byteenable[BE_W-1:0];
    assign w_sel_wdata = r_gnt ? m_writedata[2*DATA_W-1:DATA_W] : m_writedata[DATA_W-1:0];

    assign w_fifo_full  = (r_count == FULL_CNT);
    assign w_fifo_empty = (r_count == '0);

    // A read cannot issue while every ID slot is in use; the arbiter holds the
    // grant and retries each cycle, so the read goes out the cycle after a pop.
    assign w_read_blocked = w_busy & w_sel_read & w_fifo_full;

    assign w_s_read  = w_busy & w_sel_read & ~w_read_blocked;
    assign w_s_write = w_busy & w_sel_write;
    assign w_accept  = (w_s_read | w_s_write) & ~s_waitrequest;

    assign s_read       = w_s_read;
    assign s_write      = w_s_write;
    assign s_address    = w_busy ? w_sel_addr  : '0;
    assign s_byteenable = w_busy ? w_sel_be    : '0;
    assign s_writedata  = w_busy ? w_sel_wdata : '0;

    assign m_waitrequest[0] = ~(w_busy & ~r_gnt) | s_waitrequest | w_read_blocked;
    assign m_waitrequest[1] = ~(w_busy &  r_gnt) | s_waitrequest | w_read_blocked;

    // -------------------------------------------------------------------------
    // Arbitration FSM
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_gnt   <= 1'b0;
            r_last  <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_gnt   <= w_gnt_nxt;
            r_last  <= w_last_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_gnt_nxt   = r_gnt;
        w_last_nxt  = r_last;
        case (r_state)
            ST_IDLE: begin
                if (|w_req) begin
                    w_state_nxt = ST_BUSY;
                    if (&w_req) begin
                        w_gnt_nxt = ~r_last;
                    end else begin
                        w_gnt_nxt = w_req[1];
                    end
                end
            end
            ST_BUSY: begin
                if (w_accept) begin
                    w_state_nxt = ST_IDLE;
                    w_last_nxt  = r_gnt;
                end else if (!(w_sel_read | w_sel_write)) begin
                    // Granted master withdrew its request without being
                    // accepted; release the slave but keep fairness history.
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Read ID FIFO: one entry per accepted read, holding the issuing master
    // -------------------------------------------------------------------------
    assign w_push    = w_s_read & ~s_waitrequest;
    assign w_pop     = s_readdatavalid & ~w_fifo_empty;
    assign w_head_id = r_fifo[r_rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fifo   <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_fifo[r_wr_ptr] <= r_gnt;
                r_wr_ptr         <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Return path
    // -------------------------------------------------------------------------
    assign m_readdata         = s_readdata;
    assign m_readdatavalid[0] = w_pop & ~w_head_id;
    assign m_readdatavalid[1] = w_pop &  w_head_id;

    // Data with nothing outstanding has no owner; flag it until reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_rdv <= 1'b0;
        end else if (s_readdatavalid && w_fifo_empty) begin
            r_err_rdv <= 1'b1;
        end
    end

    assign err_rdv = r_err_rdv;

endmodule

// File: tb/tb_avalon_rr_arbiter2.sv
module tb_avalon_rr_arbiter2;

    localparam int ADDR_W   = 32;
    localparam int DATA_W   = 32;
    localparam int MAX_PEND = 4;

    logic                  clk;
    logic                  rst_n;
    logic [2*ADDR_W-1:0]   m_address;
    logic [1:0]            m_read;
    logic [1:0]            m_write;
    logic [2*DATA_W/8-1:0] m_byteenable;
    logic [2*DATA_W-1:0]   m_writedata;
    logic [1:0]            m_waitrequest;
    logic [DATA_W-1:0]     m_readdata;
    logic [1:0]            m_readdatavalid;
    logic [ADDR_W-1:0]     s_address;
    logic                  s_read;
    logic                  s_write;
    logic [DATA_W/8-1:0]   s_byteenable;
    logic [DATA_W-1:0]     s_writedata;
    logic                  s_waitrequest;
    logic [DATA_W-1:0]     s_readdata;
    logic                  s_readdatavalid;
    logic                  err_rdv;

    logic [31:0] ta0;
    logic [31:0] ta1;

    int n_vec;
    int n_err;

    assign m_address    = {ta1, ta0};
    assign m_writedata  = {32'h0000_5555, 32'h0000_AAAA};
    assign m_byteenable = {4'hC, 4'h3};

    avalon_rr_arbiter2 #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .MAX_PEND(MAX_PEND)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .m_address      (m_address),
        .m_read         (m_read),
        .m_write        (m_write),
        .m_byteenable   (m_byteenable),
        .m_writedata    (m_writedata),
        .m_waitrequest  (m_waitrequest),
        .m_readdata     (m_readdata),
        .m_readdatavalid(m_readdatavalid),
        .s_address      (s_address),
        .s_read         (s_read),
        .s_write        (s_write),
        .s_byteenable   (s_byteenable),
        .s_writedata    (s_writedata),
        .s_waitrequest  (s_waitrequest),
        .s_readdata     (s_readdata),
        .s_readdatavalid(s_readdatavalid),
        .err_rdv        (err_rdv)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  rd;
        logic [1:0]  wr;
        logic [31:0] a0;
        logic [31:0] a1;
        logic        sw;
        logic        srdv;
        logic [31:0] srd;
        logic        e_srd;
        logic        e_swr;
        logic [31:0] e_addr;
        logic [31:0] e_wd;
        logic [1:0]  e_mw;
        logic [1:0]  e_rdv;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic [1:0] rd, input logic [1:0] wr,
                                input logic [31:0] a0, input logic [31:0] a1,
                                input logic sw, input logic srdv, input logic [31:0] srd,
                                input logic e_srd, input logic e_swr,
                                input logic [31:0] e_addr, input logic [31:0] e_wd,
                                input logic [1:0] e_mw, input logic [1:0] e_rdv);
        vec_t v;
        v.rd = rd; v.wr = wr; v.a0 = a0; v.a1 = a1;
        v.sw = sw; v.srdv = srdv; v.srd = srd;
        v.e_srd = e_srd; v.e_swr = e_swr; v.e_addr = e_addr; v.e_wd = e_wd;
        v.e_mw = e_mw; v.e_rdv = e_rdv;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual %0h, required %0h", nm, act, exp);
        end
    endtask

    // Drive one cycle's inputs after the falling edge, then settle before sampling.
    task automatic cyc(input logic [1:0] rd, input logic [1:0] wr, input logic sw,
                       input logic srdv, input logic [31:0] srd);
        @(negedge clk);
        m_read          = rd;
        m_write         = wr;
        s_waitrequest   = sw;
        s_readdatavalid = srdv;
        s_readdata      = srd;
        #2;
        n_vec++;
    endtask

    task automatic chk_cmd(input string nm, input logic e_rd, input logic [1:0] e_mw,
                           input logic [1:0] e_rdv);
        chk({nm, " s_read"}, 64'(s_read), 64'(e_rd));
        chk({nm, " m_waitrequest"}, 64'(m_waitrequest), 64'(e_mw));
        chk({nm, " m_readdatavalid"}, 64'(m_readdatavalid), 64'(e_rdv));
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        ta0 = '0;
        ta1 = '0;
        m_read = '0;
        m_write = '0;
        s_waitrequest = 1'b0;
        s_readdatavalid = 1'b0;
        s_readdata = '0;

        // Contention: continuous writes from both masters alternate m0, m1, m0, m1.
        tbl.push_back(mk(2'b00, 2'b11, 32'h10, 32'h20, 0, 0, 0, 0, 0, 32'h0,  32'h0,    2'b11, 2'b00));
        tbl.push_back(mk(2'b00, 2'b11, 32'h10, 32'h20, 0, 0, 0, 0, 1, 32'h10, 32'hAAAA, 2'b10, 2'b00));
        tbl.push_back(mk(2'b00, 2'b11, 32'h10, 32'h20, 0, 0, 0, 0, 0, 32'h0,  32'h0,    2'b11, 2'b00));
        tbl.push_back(mk(2'b00, 2'b11, 32'h10, 32'h20, 0, 0, 0, 0, 1, 32'h20, 32'h5555, 2'b01, 2'b00));
        tbl.push_back(mk(2'b00, 2'b11, 32'h10, 32'h20, 0, 0, 0, 0, 0, 32'h0,  32'h0,    2'b11, 2'b00));
        tbl.push_back(mk(2'b00, 2'b11, 32'h10, 32'h20, 0, 0, 0, 0, 1, 32'h10, 32'hAAAA, 2'b10, 2'b00));
        tbl.push_back(mk(2'b00, 2'b10, 32'h10, 32'h20, 0, 0, 0, 0, 0, 32'h0,  32'h0,    2'b11, 2'b00));
        tbl.push_back(mk(2'b00, 2'b10, 32'h10, 32'h20, 0, 0, 0, 0, 1, 32'h20, 32'h5555, 2'b01, 2'b00));
        tbl.push_back(mk(2'b00, 2'b00, 32'h10, 32'h20, 0, 0, 0, 0, 0, 32'h0,  32'h0,    2'b11, 2'b00));
        // Single master read with two waitrequest cycles; data three cycles after accept.
        tbl.push_back(mk(2'b01, 2'b00, 32'h100, 32'h20, 1, 0, 0, 0, 0, 32'h0,   32'h0, 2'b11, 2'b00));
        tbl.push_back(mk(2'b01, 2'b00, 32'h100, 32'h20, 1, 0, 0, 1, 0, 32'h100, 32'h0, 2'b11, 2'b00));
        tbl.push_back(mk(2'b01, 2'b00, 32'h100, 32'h20, 1, 0, 0, 1, 0, 32'h100, 32'h0, 2'b11, 2'b00));
        tbl.push_back(mk(2'b01, 2'b00, 32'h100, 32'h20, 0, 0, 0, 1, 0, 32'h100, 32'h0, 2'b10, 2'b00));
        tbl.push_back(mk(2'b00, 2'b00, 32'h100, 32'h20, 0, 0, 0, 0, 0, 32'h0,   32'h0, 2'b11, 2'b00));
        tbl.push_back(mk(2'b00, 2'b00, 32'h100, 32'h20, 0, 0, 0, 0, 0, 32'h0,   32'h0, 2'b11, 2'b00));
        tbl.push_back(mk(2'b00, 2'b00, 32'h100, 32'h20, 0, 1, 32'hCAFEBABE, 0, 0, 32'h0, 32'h0, 2'b11, 2'b01));
        tbl.push_back(mk(2'b00, 2'b00, 32'h100, 32'h20, 0, 0, 0, 0, 0, 32'h0,   32'h0, 2'b11, 2'b00));
        // Pipelined reads m0, m1, m0 then three data beats routed in issue order.
        tbl.push_back(mk(2'b01, 2'b00, 32'h30, 32'h40, 0, 0, 0, 0, 0, 32'h0,  32'h0, 2'b11, 2'b00));
        tbl.push_back(mk(2'b11, 2'b00, 32'h30, 32'h40, 0, 0, 0, 1, 0, 32'h30, 32'h0, 2'b10, 2'b00));
        tbl.push_back(mk(2'b10, 2'b00, 32'h30, 32'h40, 0, 0, 0, 0, 0, 32'h0,  32'h0, 2'b11, 2'b00));
        tbl.push_back(mk(2'b11, 2'b00, 32'h30, 32'h40, 0, 0, 0, 1, 0, 32'h40, 32'h0, 2'b01, 2'b00));
        tbl.push_back(mk(2'b01, 2'b00, 32'h30, 32'h40, 0, 0, 0, 0, 0, 32'h0,  32'h0, 2'b11, 2'b00));
        tbl.push_back(mk(2'b01, 2'b00, 32'h30, 32'h40, 0, 0, 0, 1, 0, 32'h30, 32'h0, 2'b10, 2'b00));
        tbl.push_back(mk(2'b00, 2'b00, 32'h30, 32'h40, 0, 1, 32'h11111111, 0, 0, 32'h0, 32'h0, 2'b11, 2'b01));
        tbl.push_back(mk(2'b00, 2'b00, 32'h30, 32'h40, 0, 1, 32'h22222222, 0, 0, 32'h0, 32'h0, 2'b11, 2'b10));
        tbl.push_back(mk(2'b00, 2'b00, 32'h30, 32'h40, 0, 1, 32'h33333333, 0, 0, 32'h0, 32'h0, 2'b11, 2'b01));
        tbl.push_back(mk(2'b00, 2'b00, 32'h30, 32'h40, 0, 0, 0, 0, 0, 32'h0,  32'h0, 2'b11, 2'b00));

        // Reset state
        #12;
        n_vec++;
        chk_cmd("reset", 1'b0, 2'b11, 2'b00);
        chk("reset s_write", 64'(s_write), 64'(0));
        chk("reset err_rdv", 64'(err_rdv), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            ta0 = tbl[i].a0;
            ta1 = tbl[i].a1;
            cyc(tbl[i].rd, tbl[i].wr, tbl[i].sw, tbl[i].srdv, tbl[i].srd);
            chk_cmd($sformatf("v%0d", i), tbl[i].e_srd, tbl[i].e_mw, tbl[i].e_rdv);
            chk($sformatf("v%0d s_write", i), 64'(s_write), 64'(tbl[i].e_swr));
            chk($sformatf("v%0d s_address", i), 64'(s_address), 64'(tbl[i].e_addr));
            chk($sformatf("v%0d m_readdata", i), 64'(m_readdata), 64'(tbl[i].srd));
            if (tbl[i].e_swr)
                chk($sformatf("v%0d s_writedata", i), 64'(s_writedata), 64'(tbl[i].e_wd));
            chk($sformatf("v%0d err_rdv", i), 64'(err_rdv), 64'(0));
        end

        // FIFO full: four reads fill the ID FIFO, the fifth stalls until a pop.
        ta0 = 32'h50;
        for (int k = 0; k < 4; k++) begin
            cyc(2'b01, 2'b00, 0, 0, 0);
            chk_cmd($sformatf("fill%0d idle", k), 1'b0, 2'b11, 2'b00);
            cyc(2'b01, 2'b00, 0, 0, 0);
            chk_cmd($sformatf("fill%0d issue", k), 1'b1, 2'b10, 2'b00);
            chk($sformatf("fill%0d s_address", k), 64'(s_address), 64'(32'h50));
        end
        cyc(2'b01, 2'b00, 0, 0, 0);
        chk_cmd("fifth idle", 1'b0, 2'b11, 2'b00);
        for (int k = 0; k < 3; k++) begin
            cyc(2'b01, 2'b00, 0, 0, 0);
            chk_cmd($sformatf("fifth blocked%0d", k), 1'b0, 2'b11, 2'b00);
        end
        cyc(2'b01, 2'b00, 0, 1, 32'hD0D0D0D0);
        chk_cmd("fifth pop cycle", 1'b0, 2'b11, 2'b01);
        cyc(2'b01, 2'b00, 0, 0, 0);
        chk_cmd("fifth issues", 1'b1, 2'b10, 2'b00);
        cyc(2'b00, 2'b00, 0, 0, 0);
        chk_cmd("fifth done", 1'b0, 2'b11, 2'b00);
        for (int k = 0; k < 4; k++) begin
            cyc(2'b00, 2'b00, 0, 1, 32'hA0 + 32'(k));
            chk_cmd($sformatf("drain%0d", k), 1'b0, 2'b11, 2'b01);
            chk($sformatf("drain%0d m_readdata", k), 64'(m_readdata), 64'(32'hA0 + 32'(k)));
            chk($sformatf("drain%0d err_rdv", k), 64'(err_rdv), 64'(0));
        end

        // Spurious data with an empty FIFO: no strobe, sticky error.
        cyc(2'b00, 2'b00, 0, 1, 32'hBAD0BAD0);
        chk_cmd("spurious", 1'b0, 2'b11, 2'b00);
        chk("spurious err before edge", 64'(err_rdv), 64'(0));
        for (int k = 0; k < 3; k++) begin
            cyc(2'b00, 2'b00, 0, 0, 0);
            chk($sformatf("err sticky%0d", k), 64'(err_rdv), 64'(1));
            chk_cmd($sformatf("err sticky%0d", k), 1'b0, 2'b11, 2'b00);
        end

        // Reset in the middle of a stalled read from m1.
        ta1 = 32'h60;
        cyc(2'b10, 2'b00, 1, 0, 0);
        chk_cmd("rst idle", 1'b0, 2'b11, 2'b00);
        cyc(2'b10, 2'b00, 1, 0, 0);
        chk_cmd("rst busy", 1'b1, 2'b11, 2'b00);
        chk("rst busy s_address", 64'(s_address), 64'(32'h60));
        #1;
        rst_n = 1'b0;
        m_read = 2'b00;
        s_waitrequest = 1'b0;
        #1;
        n_vec++;
        chk_cmd("rst asserted", 1'b0, 2'b11, 2'b00);
        chk("rst asserted err_rdv", 64'(err_rdv), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        cyc(2'b00, 2'b00, 0, 1, 32'h77777777);
        chk_cmd("late data", 1'b0, 2'b11, 2'b00);
        cyc(2'b10, 2'b00, 0, 0, 0);
        chk("late data err_rdv", 64'(err_rdv), 64'(1));
        chk_cmd("m1 after rst idle", 1'b0, 2'b11, 2'b00);
        cyc(2'b10, 2'b00, 0, 0, 0);
        chk_cmd("m1 after rst grant", 1'b1, 2'b01, 2'b00);
        chk("m1 after rst s_address", 64'(s_address), 64'(32'h60));
        cyc(2'b00, 2'b00, 0, 0, 0);
        chk_cmd("m1 after rst done", 1'b0, 2'b11, 2'b00);
        cyc(2'b00, 2'b00, 0, 1, 32'h12345678);
        chk_cmd("m1 data", 1'b0, 2'b11, 2'b10);
        chk("m1 data m_readdata", 64'(m_readdata), 64'(32'h12345678));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/avalon_rr_arbiter2.md
Name: avalon_rr_arbiter2

Overview:
Two-master round-robin arbiter that shares one Avalon-MM slave port between the I2C-to-Avalon bridge (master 0) and a second master (master 1, e.g. debug or DMA).
- Muxes commands from the granted master onto the slave.
- Honours waitrequest.
- Tracks outstanding pipelined reads in an ID FIFO so each readdatavalid beat is returned to the master that issued the read.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width (byteenable width = DATA_W/8)
MAX_PEND, 4, max outstanding reads in flight (power of 2, >=2)

Ports:
clk  in  1  system clock
rst_n  in  1  reset
m_address  in  2*ADDR_W  master addresses, master i at bits [i*ADDR_W +: ADDR_W]
m_read  in  2  read request per master
m_write  in  2  write request per master
m_byteenable  in  2*DATA_W/8  byte enables per master
m_writedata  in  2*DATA_W  write data per master
m_waitrequest  out  2  stall per master
m_readdata  out  DATA_W  read data, broadcast to both masters
m_readdatavalid  out  2  read data valid per master
s_address  out  ADDR_W  slave address
s_read  out  1  slave read
s_write  out  1  slave write
s_byteenable  out  DATA_W/8  slave byte enables
s_writedata  out  DATA_W  slave write data
s_waitrequest  in  1  slave stall
s_readdata  in  DATA_W  slave read data
s_readdatavalid  in  1  slave read data valid
err_rdv  out  1  sticky: readdatavalid received with empty ID FIFO

Behaviour:
- Clock/reset: one clock `clk`; `rst_n` is asynchronous, active-low.
- Reset values:
  - State IDLE; gnt=0; rr pointer favours master 0; FIFO empty (count=0); err_rdv=0.
  - Hence s_read=s_write=0, m_waitrequest=2'b11, m_readdatavalid=0.
- Request: req[i] = m_read[i] | m_write[i].
- FSM states: IDLE, BUSY.
  - IDLE, any req: register gnt (winner), go BUSY next cycle. Both requesting: winner = master != last_served. Reset value of last_served=1, so master 0 wins first.
  - IDLE, no req: stay IDLE.
  - BUSY: s_* driven combinationally from master gnt. All other muxed outputs are 0 when IDLE.
  - Accept = (s_read|s_write) & ~s_waitrequest. On accept: last_served<=gnt, go IDLE.
  - Masters get one bubble cycle per transfer; max throughput is 1 transfer per 2 clocks.
  - Granted master drops req in BUSY without accept (protocol violation): go IDLE, last_served unchanged.
- Waitrequest:
  - m_waitrequest[i] = ~(BUSY & gnt==i) | s_waitrequest | read_blocked.
  - The non-granted master is always stalled.
- Read blocking: read_blocked = m_read[gnt] & (count==MAX_PEND). While set, s_read is forced 0 and the master is stalled. Arbiter stays BUSY and re-evaluates each cycle, so the blocked read issues on the cycle after a pop frees a slot.
- ID FIFO:
  - Push gnt on read accept.
  - Pop on s_readdatavalid.
  - Simultaneous push+pop: count unchanged, order preserved.
  - Pointers wrap modulo MAX_PEND.
- Return path:
  - m_readdata = s_readdata, combinational.
  - m_readdatavalid[head_id] = s_readdatavalid when count != 0.
  - s_readdatavalid with count==0: no master strobed, err_rdv set until reset.
- Writes: no FIFO effect; one cycle after accept the arbiter is IDLE.
- Simultaneous read and write from the same master: illegal, not checked; s_read and s_write are both forwarded.
- Reset mid-transfer: everything returns to reset values immediately. In-flight read data arriving afterwards sets err_rdv.

Test Plan:
1. Single master: m0 read addr 0x100, slave waitrequest held 2 cycles, readdata 0xCAFEBABE 3 cycles later -> s_read seen 3 cycles, one m_readdatavalid[0] pulse with m_readdata=0xCAFEBABE, m_readdatavalid[1] never set.
2. Contention: both masters request writes (0x10/0xAAAA from m0, 0x20/0x5555 from m1) continuously -> slave sees m0, m1, m0, m1 alternating, one idle cycle between each.
3. Pipelined reads: m0 read, m1 read, m0 read accepted before any data, slave returns D1,D2,D3 -> readdatavalid strobes [0],[1],[0] in that order with matching data.
4. FIFO full: MAX_PEND=4, five reads with no returned data -> fifth stalled (s_read=0, m_waitrequest=1) until the first readdatavalid, issues the next cycle, count never exceeds 4.
5. Spurious data: s_readdatavalid with FIFO empty -> no m_readdatavalid, err_rdv=1 and stays 1.
6. Reset mid-read: assert rst_n low while BUSY with s_waitrequest=1 -> s_read=0, m_waitrequest=11 immediately; after release, a new m1 request is granted normally.
